// File: rtl/alu4_sweep_checker.sv
// Exhaustive self-test sweep and scoreboard for a 4-bit ALU (add/sub/and/or).
// Define ALU_CHK_STOP_ON_FAIL_EN to halt the sweep at the first mismatching vector.
module alu4_sweep_checker #(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       a,
    output logic [3:0]       b,
    output logic             c1,
    output logic             c0,
    input  logic [3:0]       y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [11:0]      first_fail_vec
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       vec_q, vec_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [11:0]      ffv_q, ffv_d;

    logic [3:0] op_a, op_b, ref_y;
    logic       ref_z, mism, last, settled, launch, stop;

    assign op_a    = vec_q[7:4];
    assign op_b    = vec_q[3:0];
    assign last    = &vec_q;
    assign settled = (settle_q == SW'(SETTLE - 1));
    assign launch  = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        ref_y = 4'h0;
        unique case (vec_q[9:8])
            2'b00: ref_y = op_a + op_b;
            2'b01: ref_y = op_a - op_b;
            2'b10: ref_y = op_a & op_b;
            2'b11: ref_y = op_a | op_b;
        endcase
    end

    assign ref_z = (ref_y == 4'h0);
    assign mism  = (y != ref_y) || (z != ref_z);

`ifdef ALU_CHK_STOP_ON_FAIL_EN
    assign stop = mism;
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (launch) state_d = DRIVE;
            DRIVE: if (settled) state_d = CHECK;
            CHECK: state_d = (last || stop) ? DONE : DRIVE;
            DONE:  if (launch) state_d = DRIVE;
        endcase
    end

    always_comb begin
        busy = (state_q == DRIVE) || (state_q == CHECK);
        done = (state_q == DONE);
        pass = done && (err_q == '0);
    end

    // Datapath: vector index, settle timer, error counter, first-failure latch
    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        unique case (1'b1)
            launch: begin
                vec_d    = '0;
                settle_d = '0;
                err_d    = '0;
                ffv_d    = '0;
            end
            state_q == DRIVE: begin
                settle_d = settled ? '0 : settle_q + 1'b1;
            end
            state_q == CHECK: begin
                if (mism) begin
                    if (!(&err_q)) err_d = err_q + 1'b1;
                    if (err_q == '0) ffv_d = {2'b00, vec_q};
                end
                if (!last && !stop) vec_d = vec_q + 10'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffv_q    <= '0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
        end
    end

    assign {c1, c0, a, b}  = vec_q;
    assign err_cnt         = err_q;
    assign first_fail_vec  = ffv_q;

endmodule

// File: tb/tb_alu4_sweep_checker.sv
// Randomized fault-injection bench for alu4_sweep_checker (ERR_W=8 and 10 side by side).
// Honours ALU_CHK_STOP_ON_FAIL_EN for the expected sweep length.
module tb_alu4_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic [3:0] a8, b8, y8, a10, b10, y10;
    logic       c18, c08, z8, busy8, done8, pass8;
    logic       c110, c010, z10, busy10, done10, pass10;
    logic [7:0] err8;
    logic [9:0] err10;
    logic [11:0] ffv8, ffv10;

    int n_chk = 0;
    int n_fail = 0;

    int       mode;
    int       epoch;
    logic [3:0] fmask [1024];
    logic       fz    [1024];

    always #5 clk = ~clk;

    alu4_sweep_checker #(.SETTLE(1), .ERR_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a8), .b(b8), .c1(c18), .c0(c08), .y(y8), .z(z8),
        .busy(busy8), .done(done8), .pass(pass8),
        .err_cnt(err8), .first_fail_vec(ffv8)
    );

    alu4_sweep_checker #(.SETTLE(1), .ERR_W(10)) u10 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a10), .b(b10), .c1(c110), .c0(c010), .y(y10), .z(z10),
        .busy(busy10), .done(done10), .pass(pass10),
        .err_cnt(err10), .first_fail_vec(ffv10)
    );

    function automatic int ref_y(input int v);
        int ra, rb, op;
        ra = (v >> 4) & 15;
        rb = v & 15;
        op = (v >> 8) & 3;
        case (op)
            0:       return (ra + rb) % 16;
            1:       return (ra - rb + 16) % 16;
            2:       return ra & rb;
            default: return ra | rb;
        endcase
    endfunction

    // ALU under test: reference plus the currently selected fault
    function automatic logic [4:0] alu(input int v);
        logic [3:0] yy;
        logic       zz;
        yy = 4'(ref_y(v));
        zz = (yy == 4'h0);
        if (mode == 1) yy[0] = 1'b0;
        if (mode == 2) begin
            yy = yy ^ fmask[v];
            zz = zz ^ fz[v];
        end
        return {zz, yy};
    endfunction

    always @(a8 or b8 or c18 or c08 or epoch)
        {z8, y8} = alu(int'({c18, c08, a8, b8}));
    always @(a10 or b10 or c110 or c010 or epoch)
        {z10, y10} = alu(int'({c110, c010, a10, b10}));

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: edges since accepted start, mismatch prefix sums
    bit started;
    int n, len, ff;
    int pre [1025];

    task automatic build_model();
        int m;
        pre[0] = 0;
        ff = 1024;
        for (int v = 0; v < 1024; v++) begin
            m = (alu(v) != {ref_y(v) == 0, 4'(ref_y(v))}) ? 1 : 0;
            pre[v+1] = pre[v] + m;
            if (m == 1 && ff == 1024) ff = v;
        end
        len = 2048;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        if (ff < 1024) len = 2 * (ff + 1);
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started = 0;
            n = 0;
        end else if (start && (!started || n >= len)) begin
            build_model();
            started = 1;
            n = 0;
        end else if (started && n < len) begin
            n = n + 1;
        end
    end

    always @(negedge clk) begin
        int chk, vec, e_busy, e_done, e_err8, e_err10, e_ffv, e_pass;
        if (!started) begin
            chk = 0; vec = 0; e_busy = 0; e_done = 0;
            e_err8 = 0; e_err10 = 0; e_ffv = 0; e_pass = 0;
        end else begin
            e_busy = (n < len) ? 1 : 0;
            e_done = 1 - e_busy;
            chk    = e_busy ? n / 2 : len / 2;
            vec    = e_busy ? n / 2 : len / 2 - 1;
            e_err8  = (pre[chk] > 255) ? 255 : pre[chk];
            e_err10 = (pre[chk] > 1023) ? 1023 : pre[chk];
            e_ffv  = (ff < chk) ? ff : 0;
            e_pass = (e_done == 1 && pre[chk] == 0) ? 1 : 0;
        end
        check("vec8",   int'({c18, c08, a8, b8}), vec);
        check("vec10",  int'({c110, c010, a10, b10}), vec);
        check("busy8",  int'(busy8), e_busy);
        check("busy10", int'(busy10), e_busy);
        check("done8",  int'(done8), e_done);
        check("done10", int'(done10), e_done);
        check("pass8",  int'(pass8), e_pass);
        check("pass10", int'(pass10), e_pass);
        check("err8",   int'(err8), e_err8);
        check("err10",  int'(err10), e_err10);
        check("ffv8",   int'(ffv8), e_ffv);
        check("ffv10",  int'(ffv10), e_ffv);
    end

    task automatic run_sweep(input int pulse_at, output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_err10", int'(err10), 0);
        check("restart_ffv8", int'(ffv8), 0);
        check("restart_vec8", int'({c18, c08, a8, b8}), 0);
        check("restart_busy8", int'(busy8), 1);
        cyc = 0;
        while (!done8 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == pulse_at);
        end
        start = 1'b0;
        check("done_seen", int'(done8), 1);
    endtask

    initial begin
        int cyc, exp_cyc;
        mode  = 0;
        epoch = 0;
        rst_n = 1'b0;
        start = 1'b0;
        for (int v = 0; v < 1024; v++) begin
            fmask[v] = 4'h0;
            fz[v]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_err8", int'(err8), 0);
        check("rst_done10", int'(done10), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Healthy ALU
        run_sweep(0, cyc);
        check("t1_cycles", cyc, 2048);
        check("t1_pass", int'(pass10), 1);
        check("t1_err", int'(err10), 0);
        check("t1_ffv", int'(ffv10), 0);

        // y[0] stuck-at-0, restart from DONE, ignored start mid-sweep
        mode = 1;
        epoch++;
        run_sweep(100, cyc);
        check("model_total", pre[1024], 512);
        check("model_first", ff, 1);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        check("t2_cycles", cyc, 4);
        check("t2_err10", int'(err10), 1);
        check("t2_err8", int'(err8), 1);
        check("t2_a", int'(a8), 0);
        check("t2_b", int'(b8), 1);
        check("t2_op", int'({c18, c08}), 0);
`else
        check("t2_cycles", cyc, 2048);
        check("t2_err10", int'(err10), 512);
        check("t2_err8", int'(err8), 255);
`endif
        check("t2_ffv", int'(ffv10), 12'h001);
        check("t2_pass", int'(pass8), 0);

        // Random fault patterns, sparse and dense
        for (int it = 0; it < 3; it++) begin
            mode = 2;
            for (int v = 0; v < 1024; v++) begin
                if (it == 1)
                    fmask[v] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                else
                    fmask[v] = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                fz[v] = ($urandom_range(0, 39) == 0);
            end
            epoch++;
            run_sweep($urandom_range(1, 1500), cyc);
            exp_cyc = len;
            check("rnd_cycles", cyc, exp_cyc);
        end

        // Reset in mid-sweep, then a clean fresh run
        mode = 0;
        epoch++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (699) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy8), 0);
        check("arst_vec", int'({c110, c010, a10, b10}), 0);
        check("arst_err", int'(err10), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(0, cyc);
        check("t5_cycles", cyc, 2048);
        check("t5_pass", int'(pass8), 1);
        check("t5_err", int'(err8), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
